hdmi_pattern_gen: RTL and testbench
===================================

Name: hdmi_pattern_gen

Overview:
Parametrised video timing and test-pattern source for the HDMI output path. It sits in front of the TMDS encoders in the pixel-clock domain and drives hsync, vsync, data-enable and RGB. It generalises the fixed-mode test source with programmable timing, sync polarity and colour depth. It adds four runtime-selectable patterns, a frame-start strobe, and an enable that allows glitch-free start and stop.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level
BPC, 8, bits per colour component
CW, 12, counter and coordinate width; must cover H_TOTAL and V_TOTAL
CHECK_LOG2, 5, log2 of checkerboard square size (pixels)

Ports:
sys_clock    in   1        pixel clock
sys_rst      in   1        asynchronous active-high reset
enable       in   1        run timing; low = idle
pattern_sel  in   2        0 bars, 1 gradient, 2 checker, 3 solid
solid_rgb    in   3*BPC    {R,G,B} colour for pattern 3
hsync        out  1        horizontal sync
vsync        out  1        vertical sync
de           out  1        data enable, high in the active area
rgb          out  3*BPC    {R,G,B} pixel
pix_x        out  CW       x coordinate aligned with rgb
pix_y        out  CW       y coordinate aligned with rgb
frame_start  out  1        one-cycle pulse on pixel (0,0)

Behaviour:
- Clock and reset: one clock, sys_clock. Reset is asynchronous and active-high (sys_rst).
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL analogous.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; it runs 0..V_TOTAL-1 and wraps to 0.
- Timing decode (per counter value):
  - Active: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). vsync edges coincide with h_cnt=0.
- Output registration and latency:
  - All outputs are registered, one cycle after the counter value they describe.
  - hsync, vsync, de, rgb, pix_x, pix_y and frame_start stay mutually aligned.
- Reset values (sys_rst high, asynchronous):
  - h_cnt=0, v_cnt=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - de=0, rgb=0, pix_x=0, pix_y=0, frame_start=0.
  - Latched pattern = 0, latched solid = 0.
- Enable:
  - enable low: counters held at 0, outputs at reset values.
  - Dropping enable mid-frame aborts immediately. The next cycle shows idle outputs; no partial-line completion.
  - Raising enable starts at (0,0); the first active pixel appears one cycle later together with frame_start.
- Pattern and colour latching:
  - pattern_sel and solid_rgb are latched only when h_cnt=0 and v_cnt=0 with enable high, so a frame is never torn.
  - Changes mid-frame take effect from the next frame.
- Pixel value when de=1 (x=h_cnt, y=v_cnt); rgb=0 whenever de=0:
  - 0 colour bars:
    - BW = H_ACTIVE/8 (integer division); bar index = min(x/BW, 7).
    - Bars 0..7 in order: white, yellow, cyan, green, magenta, red, blue, black. Remainder pixels take black.
    - Components are full-scale (all ones) or 0.
  - 1 gradient: R=G=B=x[BPC-1:0], wrapping modulo 2^BPC.
  - 2 checkerboard: white if x[CHECK_LOG2]^y[CHECK_LOG2] = 0, else black.
  - 3 solid: latched solid_rgb.
- pix_x/pix_y equal the counters during the active area and 0 otherwise.
- frame_start is high exactly one cycle per frame.
- Counter arithmetic is CW-bit unsigned with no overflow; a parameter check errors at elaboration if H_TOTAL or V_TOTAL exceeds 2^CW.

Test Plan:
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=8, V_FP=1, V_SYNC=2, V_BP=1, BPC=8, CHECK_LOG2=2. This gives H_TOTAL=24, V_TOTAL=12 and 288 cycles per frame.
- Reset and timing:
  - Stimulus: assert sys_rst mid-clock, release it, hold enable=1.
  - Required: outputs idle (hsync=1, vsync=1, de=0, rgb=0) during reset. After release, de is high 16 of every 24 cycles. hsync is low for 3 cycles starting 18 cycles after de rises. frame_start repeats every 288 cycles.
- Vertical timing:
  - Required: de lines 0..7. vsync low for exactly 48 cycles (lines 9–10), its falling edge aligned with the hsync period start.
- Colour bars (pattern_sel=0):
  - Required line 0: pixels 0–1 = FFFFFF, 2–3 = FFFF00, 4–5 = 00FFFF, 6–7 = 00FF00, 8–9 = FF00FF, 10–11 = FF0000, 12–13 = 0000FF, 14–15 = 000000.
- Latching:
  - Stimulus: change pattern_sel 0->2 at line 3.
  - Required: the rest of that frame stays bars. The next frame is a checker: pixel (0,0) = FFFFFF, (4,0) = 000000, (4,4) = FFFFFF.
- Gradient and solid:
  - pattern_sel=1: rgb at x=5 is 050505.
  - pattern_sel=3 with solid_rgb=123456: every active pixel is 123456 and blanking is 000000.
- Enable abort:
  - Stimulus: drop enable at line 4, pixel 7.
  - Required: the next cycle is idle. After re-enable, frame_start arrives one cycle later with pix_x=0, pix_y=0.

Source files
------------

// File: rtl/hdmi_pattern_gen_if.sv
// Video source interface: runtime controls in, timed pixel stream out.
//   enable       run timing; low = idle
//   pattern_sel  0 bars, 1 gradient, 2 checker, 3 solid
//   solid_rgb    {R,G,B} colour for the solid pattern
//   hsync/vsync  sync outputs, polarity set by the generator
//   de           data enable, high in the active area
//   rgb          {R,G,B} pixel
//   pix_x/pix_y  coordinate aligned with rgb (0 outside the active area)
//   frame_start  one-cycle pulse on pixel (0,0)
interface hdmi_pattern_gen_if #(
    parameter int unsigned BPC = 8,
    parameter int unsigned CW  = 12
);
    logic                 enable;
    logic [1:0]           pattern_sel;
    logic [3*BPC-1:0]     solid_rgb;
    logic                 hsync;
    logic                 vsync;
    logic                 de;
    logic [3*BPC-1:0]     rgb;
    logic [CW-1:0]        pix_x;
    logic [CW-1:0]        pix_y;
    logic                 frame_start;

    // Generator side
    modport master (
        input  enable, pattern_sel, solid_rgb,
        output hsync, vsync, de, rgb, pix_x, pix_y, frame_start
    );

    // Consumer / controller side
    modport slave (
        output enable, pattern_sel, solid_rgb,
        input  hsync, vsync, de, rgb, pix_x, pix_y, frame_start
    );
endinterface

// File: rtl/hdmi_pattern_gen.sv
// Programmable video timing and test-pattern source in the pixel-clock domain.
//   sys_clock  pixel clock
//   sys_rst    asynchronous active-high reset
//   vid        hdmi_pattern_gen_if master: controls in, sync/de/rgb/coords out
// All outputs are registered one cycle after the counter value they describe.
module hdmi_pattern_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned BPC        = 8,
    parameter int unsigned CW         = 12,
    parameter int unsigned CHECK_LOG2 = 5
) (
    input  logic                sys_clock,
    input  logic                sys_rst,
    hdmi_pattern_gen_if.master  vid
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;
    localparam int unsigned PW       = 3 * BPC;

    // Elaboration-time parameter sanity
    if (64'(H_TOTAL) > (64'd1 << CW)) begin : g_h_total_chk
        $error("hdmi_pattern_gen: H_TOTAL does not fit in CW bits");
    end
    if (64'(V_TOTAL) > (64'd1 << CW)) begin : g_v_total_chk
        $error("hdmi_pattern_gen: V_TOTAL does not fit in CW bits");
    end
    if (BAR_W == 0) begin : g_bar_chk
        $error("hdmi_pattern_gen: H_ACTIVE must be at least 8");
    end
    if (CHECK_LOG2 >= CW) begin : g_chk_chk
        $error("hdmi_pattern_gen: CHECK_LOG2 must be below CW");
    end

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [1:0]    pat_q, pat_d;
    logic [PW-1:0] solid_q, solid_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [PW-1:0] rgb_q, rgb_d;
    logic [CW-1:0] pix_x_q, pix_x_d;
    logic [CW-1:0] pix_y_q, pix_y_d;
    logic          frame_start_q, frame_start_d;

    logic          at_origin;
    logic          active;
    logic [CW-1:0] bar_raw;
    logic [2:0]    bar_idx;

    // Bar index, clamped so remainder pixels fall into the black bar
    assign bar_raw = h_cnt_q / CW'(BAR_W);
    assign bar_idx = (bar_raw > CW'(7)) ? 3'd7 : bar_raw[2:0];

    assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign active    = (h_cnt_q < CW'(H_ACTIVE)) && (v_cnt_q < CW'(V_ACTIVE));

    // Next-state: counters, frame-boundary latching and output decode
    always_comb begin
        h_cnt_d       = '0;
        v_cnt_d       = '0;
        pat_d         = pat_q;
        solid_d       = solid_q;
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        de_d          = 1'b0;
        rgb_d         = '0;
        pix_x_d       = '0;
        pix_y_d       = '0;
        frame_start_d = 1'b0;

        if (vid.enable) begin
            if (h_cnt_q == CW'(H_TOTAL - 1)) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == CW'(V_TOTAL - 1)) ? '0 : v_cnt_q + CW'(1);
            end else begin
                h_cnt_d = h_cnt_q + CW'(1);
                v_cnt_d = v_cnt_q;
            end

            // Controls sampled only at (0,0); pixel (0,0) already uses the new values
            if (at_origin) begin
                pat_d   = vid.pattern_sel;
                solid_d = vid.solid_rgb;
            end

            if ((h_cnt_q >= CW'(HS_START)) && (h_cnt_q < CW'(HS_END))) hsync_d = HS_POL;
            if ((v_cnt_q >= CW'(VS_START)) && (v_cnt_q < CW'(VS_END))) vsync_d = VS_POL;

            frame_start_d = at_origin;
            de_d          = active;

            if (active) begin
                pix_x_d = h_cnt_q;
                pix_y_d = v_cnt_q;
                case (pat_d)
                    2'd0:    rgb_d = {{BPC{~bar_idx[1]}}, {BPC{~bar_idx[2]}}, {BPC{~bar_idx[0]}}};
                    2'd1:    rgb_d = {3{BPC'(h_cnt_q)}};
                    2'd2:    rgb_d = (h_cnt_q[CHECK_LOG2] ^ v_cnt_q[CHECK_LOG2]) ? '0 : '1;
                    default: rgb_d = solid_d;
                endcase
            end
        end
    end

    // State and output registers
    always_ff @(posedge sys_clock or posedge sys_rst) begin
        if (sys_rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pat_q         <= '0;
            solid_q       <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pat_q         <= pat_d;
            solid_q       <= solid_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.rgb         = rgb_q;
    assign vid.pix_x       = pix_x_q;
    assign vid.pix_y       = pix_y_q;
    assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Directed bench for hdmi_pattern_gen with a 24x12 total raster (16x8 active).
module tb_hdmi_pattern_gen;

    localparam int unsigned FRAME = 288;

    logic sys_clock = 1'b0;
    logic sys_rst   = 1'b0;
    always #5 sys_clock = ~sys_clock;

    int checks   = 0;
    int failures = 0;

    hdmi_pattern_gen_if #(.BPC(8), .CW(12)) vid ();

    hdmi_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .BPC(8), .CW(12), .CHECK_LOG2(2)
    ) dut (
        .sys_clock (sys_clock),
        .sys_rst   (sys_rst),
        .vid       (vid)
    );

    // One captured frame, index k = line*24 + pixel; index FRAME is the next frame's first sample
    logic [23:0] c_rgb [FRAME+1];
    logic        c_de  [FRAME+1];
    logic        c_hs  [FRAME+1];
    logic        c_vs  [FRAME+1];
    logic        c_fs  [FRAME+1];
    logic [11:0] c_px  [FRAME+1];
    logic [11:0] c_py  [FRAME+1];

    // Samples on negedges starting now; optionally changes controls after sample chg_k
    task automatic capture(input int chg_k, input logic [1:0] new_sel, input logic [23:0] new_solid);
        for (int k = 0; k <= int'(FRAME); k++) begin
            c_rgb[k] = vid.rgb;
            c_de[k]  = vid.de;
            c_hs[k]  = vid.hsync;
            c_vs[k]  = vid.vsync;
            c_fs[k]  = vid.frame_start;
            c_px[k]  = vid.pix_x;
            c_py[k]  = vid.pix_y;
            if (k == chg_k) begin
                vid.pattern_sel = new_sel;
                vid.solid_rgb   = new_solid;
            end
            if (k < int'(FRAME)) @(negedge sys_clock);
        end
    endtask

    task automatic test_reset;
        vid.enable      = 1'b1;
        vid.pattern_sel = 2'd0;
        vid.solid_rgb   = 24'h0;
        #2 sys_rst = 1'b1;
        #20;
        checks++; if (vid.hsync !== 1'b1) begin failures++; $display("FAIL rst_hsync got=%b exp=1", vid.hsync); end
        checks++; if (vid.vsync !== 1'b1) begin failures++; $display("FAIL rst_vsync got=%b exp=1", vid.vsync); end
        checks++; if (vid.de !== 1'b0) begin failures++; $display("FAIL rst_de got=%b exp=0", vid.de); end
        checks++; if (vid.rgb !== 24'h0) begin failures++; $display("FAIL rst_rgb got=%h exp=000000", vid.rgb); end
        checks++; if (vid.frame_start !== 1'b0) begin failures++; $display("FAIL rst_fs got=%b exp=0", vid.frame_start); end
        checks++; if (vid.pix_x !== 12'd0) begin failures++; $display("FAIL rst_pix_x got=%0d exp=0", vid.pix_x); end
        @(negedge sys_clock);
        sys_rst = 1'b0;
        @(negedge sys_clock);
        checks++; if (vid.frame_start !== 1'b1) begin failures++; $display("FAIL first_fs got=%b exp=1", vid.frame_start); end
        checks++; if (vid.de !== 1'b1) begin failures++; $display("FAIL first_de got=%b exp=1", vid.de); end
        checks++; if (vid.pix_y !== 12'd0) begin failures++; $display("FAIL first_pix_y got=%0d exp=0", vid.pix_y); end
    endtask

    task automatic test_htiming;
        int n_de;
        int n_hs;
        n_de = 0;
        n_hs = 0;
        capture(-1, 2'd0, 24'h0);
        for (int k = 0; k < 24; k++) begin
            if (c_de[k] === 1'b1) n_de++;
            if (c_hs[k] === 1'b0) n_hs++;
        end
        checks++; if (n_de != 16) begin failures++; $display("FAIL de_per_line got=%0d exp=16", n_de); end
        checks++; if (c_de[16] !== 1'b0) begin failures++; $display("FAIL de_x16 got=%b exp=0", c_de[16]); end
        checks++; if (n_hs != 3) begin failures++; $display("FAIL hs_width got=%0d exp=3", n_hs); end
        checks++; if (c_hs[17] !== 1'b1) begin failures++; $display("FAIL hs_17 got=%b exp=1", c_hs[17]); end
        checks++; if (c_hs[18] !== 1'b0) begin failures++; $display("FAIL hs_18 got=%b exp=0", c_hs[18]); end
        checks++; if (c_hs[21] !== 1'b1) begin failures++; $display("FAIL hs_21 got=%b exp=1", c_hs[21]); end
        checks++; if (c_fs[FRAME] !== 1'b1) begin failures++; $display("FAIL fs_period got=%b exp=1", c_fs[FRAME]); end
    endtask

    // Uses the frame captured by test_htiming
    task automatic test_vtiming;
        int n_de;
        int n_vs;
        int n_fs;
        n_de = 0;
        n_vs = 0;
        n_fs = 0;
        for (int k = 0; k < int'(FRAME); k++) begin
            if (c_de[k] === 1'b1) n_de++;
            if (c_vs[k] === 1'b0) n_vs++;
            if (c_fs[k] === 1'b1) n_fs++;
        end
        checks++; if (n_de != 128) begin failures++; $display("FAIL de_total got=%0d exp=128", n_de); end
        checks++; if (c_de[7*24] !== 1'b1) begin failures++; $display("FAIL de_line7 got=%b exp=1", c_de[7*24]); end
        checks++; if (c_de[8*24] !== 1'b0) begin failures++; $display("FAIL de_line8 got=%b exp=0", c_de[8*24]); end
        checks++; if (n_vs != 48) begin failures++; $display("FAIL vs_width got=%0d exp=48", n_vs); end
        checks++; if (c_vs[215] !== 1'b1) begin failures++; $display("FAIL vs_215 got=%b exp=1", c_vs[215]); end
        checks++; if (c_vs[216] !== 1'b0) begin failures++; $display("FAIL vs_216 got=%b exp=0", c_vs[216]); end
        checks++; if (c_vs[264] !== 1'b1) begin failures++; $display("FAIL vs_264 got=%b exp=1", c_vs[264]); end
        checks++; if (n_fs != 1) begin failures++; $display("FAIL fs_count got=%0d exp=1", n_fs); end
    endtask

    // Uses the same frame; pattern 0 is active
    task automatic test_bars;
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        for (int x = 0; x < 16; x++) begin
            checks++;
            if (c_rgb[x] !== bars[x/2]) begin
                failures++; $display("FAIL bar_x%0d got=%h exp=%h", x, c_rgb[x], bars[x/2]);
            end
        end
        checks++; if (c_rgb[16] !== 24'h0) begin failures++; $display("FAIL bar_blank got=%h exp=000000", c_rgb[16]); end
        checks++; if (c_px[5] !== 12'd5) begin failures++; $display("FAIL pix_x5 got=%0d exp=5", c_px[5]); end
        checks++; if (c_py[3*24+2] !== 12'd3) begin failures++; $display("FAIL pix_y3 got=%0d exp=3", c_py[3*24+2]); end
        checks++; if (c_px[20] !== 12'd0) begin failures++; $display("FAIL pix_x_blank got=%0d exp=0", c_px[20]); end
        checks++; if (c_py[8*24+3] !== 12'd0) begin failures++; $display("FAIL pix_y_blank got=%0d exp=0", c_py[8*24+3]); end
    endtask

    task automatic test_latching;
        capture(3*24, 2'd2, 24'h0);
        checks++; if (c_rgb[4*24+14] !== 24'h000000) begin failures++; $display("FAIL latch_hold_14_4 got=%h exp=000000", c_rgb[4*24+14]); end
        checks++; if (c_rgb[7*24+4] !== 24'h00FFFF) begin failures++; $display("FAIL latch_hold_4_7 got=%h exp=00FFFF", c_rgb[7*24+4]); end
        capture(-1, 2'd2, 24'h0);
        checks++; if (c_fs[0] !== 1'b1) begin failures++; $display("FAIL chk_fs got=%b exp=1", c_fs[0]); end
        checks++; if (c_rgb[0] !== 24'hFFFFFF) begin failures++; $display("FAIL chk_0_0 got=%h exp=FFFFFF", c_rgb[0]); end
        checks++; if (c_rgb[4] !== 24'h000000) begin failures++; $display("FAIL chk_4_0 got=%h exp=000000", c_rgb[4]); end
        checks++; if (c_rgb[4*24+4] !== 24'hFFFFFF) begin failures++; $display("FAIL chk_4_4 got=%h exp=FFFFFF", c_rgb[4*24+4]); end
    endtask

    task automatic test_gradient;
        capture(10, 2'd1, 24'h0);
        checks++; if (c_rgb[24+4] !== 24'h000000) begin failures++; $display("FAIL grad_hold_4_1 got=%h exp=000000", c_rgb[24+4]); end
        capture(-1, 2'd1, 24'h0);
        checks++; if (c_rgb[5] !== 24'h050505) begin failures++; $display("FAIL grad_x5 got=%h exp=050505", c_rgb[5]); end
        checks++; if (c_rgb[2*24+15] !== 24'h0F0F0F) begin failures++; $display("FAIL grad_x15 got=%h exp=0F0F0F", c_rgb[2*24+15]); end
        checks++; if (c_rgb[2*24+16] !== 24'h000000) begin failures++; $display("FAIL grad_blank got=%h exp=000000", c_rgb[2*24+16]); end
    endtask

    task automatic test_solid;
        int bad_act;
        int bad_blank;
        bad_act   = 0;
        bad_blank = 0;
        capture(10, 2'd3, 24'h123456);
        capture(100, 2'd3, 24'hABCDEF);
        for (int k = 0; k < int'(FRAME); k++) begin
            if (((k % 24) < 16) && ((k / 24) < 8)) begin
                if (c_rgb[k] !== 24'h123456) bad_act++;
            end else begin
                if (c_rgb[k] !== 24'h000000) bad_blank++;
            end
        end
        checks++; if (bad_act != 0) begin failures++; $display("FAIL solid_active bad=%0d exp=0", bad_act); end
        checks++; if (bad_blank != 0) begin failures++; $display("FAIL solid_blank bad=%0d exp=0", bad_blank); end
    endtask

    task automatic test_enable_abort;
        int idle_bad;
        int n_fs;
        idle_bad = 0;
        n_fs     = 0;
        for (int i = 0; i < 4*24+7; i++) @(negedge sys_clock);
        checks++; if (vid.pix_x !== 12'd7) begin failures++; $display("FAIL abort_pre_x got=%0d exp=7", vid.pix_x); end
        checks++; if (vid.pix_y !== 12'd4) begin failures++; $display("FAIL abort_pre_y got=%0d exp=4", vid.pix_y); end
        checks++; if (vid.rgb !== 24'hABCDEF) begin failures++; $display("FAIL abort_pre_rgb got=%h exp=ABCDEF", vid.rgb); end
        vid.enable = 1'b0;
        @(negedge sys_clock);
        checks++; if (vid.de !== 1'b0) begin failures++; $display("FAIL abort_de got=%b exp=0", vid.de); end
        checks++; if (vid.rgb !== 24'h0) begin failures++; $display("FAIL abort_rgb got=%h exp=000000", vid.rgb); end
        checks++; if (vid.pix_x !== 12'd0) begin failures++; $display("FAIL abort_pix_x got=%0d exp=0", vid.pix_x); end
        checks++; if ({vid.hsync, vid.vsync} !== 2'b11) begin failures++; $display("FAIL abort_sync got=%b exp=11", {vid.hsync, vid.vsync}); end
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clock);
            if (vid.de !== 1'b0 || vid.frame_start !== 1'b0 || vid.hsync !== 1'b1) idle_bad++;
        end
        checks++; if (idle_bad != 0) begin failures++; $display("FAIL idle_hold bad=%0d exp=0", idle_bad); end
        vid.enable = 1'b1;
        @(negedge sys_clock);
        checks++; if (vid.frame_start !== 1'b1) begin failures++; $display("FAIL reen_fs got=%b exp=1", vid.frame_start); end
        checks++; if ({vid.pix_x, vid.pix_y} !== 24'h0) begin failures++; $display("FAIL reen_xy got=%h exp=000000", {vid.pix_x, vid.pix_y}); end
        checks++; if (vid.de !== 1'b1) begin failures++; $display("FAIL reen_de got=%b exp=1", vid.de); end
        capture(-1, 2'd3, 24'hABCDEF);
        for (int k = 0; k < int'(FRAME); k++) if (c_fs[k] === 1'b1) n_fs++;
        checks++; if (n_fs != 1 || c_fs[FRAME] !== 1'b1) begin failures++; $display("FAIL reen_period count=%0d next=%b exp=1/1", n_fs, c_fs[FRAME]); end
    endtask

    initial begin
        test_reset();
        test_htiming();
        test_vtiming();
        test_bars();
        test_latching();
        test_gradient();
        test_solid();
        test_enable_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
